mult_div_unit: RTL and testbench

Iterative 32-bit multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS datapath. It sits directly downstream of the 32-bit operand-select muxes and consumes the selected rs/rt values. It executes MULT, MULTU, DIV and DIVU over 33 cycles and raises `busy` so the controller can stall. It also serves MFHI/MFLO reads and MTHI/MTLO writes.

---
 rtl/mult_div_unit.sv | 141 ++++++++++++++
 tb/tb_mult_div_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit with architectural HI/LO.
//   MULT/MULTU: 32 shift-add steps, LSB-first over the multiplier.
//   DIV/DIVU  : 32 restoring steps, MSB-first over the dividend.
//   Signed ops work on magnitudes; the sign fix-up is applied in FIX.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start, op, a, b launch request (op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   hi_we, lo_we    MTHI/MTLO enables (honoured only when idle, no start)
//   wdata           MTHI/MTLO data
//   busy, done      registered status; done pulses once with the result
//   hi, lo          architectural registers (MFHI/MFLO read them directly)
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic               is_div;
  logic               neg_q;    // negate product / quotient
  logic               neg_rem;  // remainder follows dividend sign
  logic               b_zero;
  logic [WIDTH-1:0]   mag_a;    // multiplier (shifts right) or dividend (shifts left)
  logic [WIDTH-1:0]   mag_b;    // multiplicand or divisor
  logic [2*WIDTH-1:0] acc;      // product, or {remainder, quotient}
  logic [CW-1:0]      cnt;

  // Operand magnitudes at launch
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign abs_a = a_neg ? -a : a;
  assign abs_b = b_neg ? -b : b;

  // Multiply step: add into the upper half, then shift the whole acc right.
  // After WIDTH steps the product has walked down into its final position.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mag_a[0] ? {1'b0, mag_b} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide step: shifted remainder is < 2*divisor, so a WIDTH+1 bit
  // subtract is enough and its top bit is the borrow.
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_borrow;
  logic [2*WIDTH-1:0] div_next;
  assign div_shift  = {acc[2*WIDTH-1:WIDTH], mag_a[WIDTH-1]};
  assign div_diff   = div_shift - {1'b0, mag_b};
  assign div_borrow = div_diff[WIDTH];
  assign div_next   = {(div_borrow ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                       acc[WIDTH-2:0], ~div_borrow};

  // Sign fix-up. With b == 0 the restoring loop already leaves |a| as the
  // remainder, and re-applying a's sign gives back the original a, so only
  // the quotient needs forcing to all ones.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = b_zero ? '1 : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
  assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      acc     <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      mag_a   <= '0;
      mag_b   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div  <= op[1];
            neg_q   <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            b_zero  <= (b == '0);
            mag_a   <= abs_a;
            mag_b   <= abs_b;
            acc     <= '0;
            cnt     <= CW'(WIDTH - 1);
            busy    <= 1'b1;
            state   <= CALC;
          end else begin
            // start has priority over MT writes in the same cycle
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          if (is_div) begin
            acc   <= div_next;
            mag_a <= mag_a << 1;
          end else begin
            acc   <= mul_next;
            mag_a <= mag_a >> 1;
          end
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        rst_n, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a, b, eh, el;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] eh, el;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_pass = 0;
  int   busy_run = 0, done_cnt = 0, run_base = 0;

  // Monitor: busy length and done pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n && busy) busy_run++;
    if (done) done_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drive start for one edge; scoreboard the expected result if requested
  task automatic launch(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                        input bit push);
    exp_t e;
    op = o; a = x; b = y; start = 1'b1;
    run_base = busy_run;
    if (push) begin e.name = name; e.eh = eh; e.el = el; sb.push_back(e); end
    tick(1);
    start = 1'b0;
  endtask

  task automatic finish_op();
    exp_t e;
    int   i;
    i = 0;
    while (!done && i < 100) begin tick(1); i++; end
    if (!done) begin
      n_chk++;
      $display("FAIL done_timeout: no done within 100 cycles");
      return;
    end
    if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL scoreboard: done with empty queue, hi=%0h lo=%0h", hi, lo);
      return;
    end
    e = sb.pop_front();
    chk({e.name, "_hi"}, 64'(hi), 64'(e.eh));
    chk({e.name, "_lo"}, 64'(lo), 64'(e.el));
    chk({e.name, "_busy_cycles"}, 64'(busy_run - run_base), 64'd33);
    chk({e.name, "_busy_at_done"}, 64'(busy), 64'd0);
    tick(1);
    chk({e.name, "_done_one_cycle"}, 64'(done), 64'd0);
    chk({e.name, "_idle_after"}, 64'(busy), 64'd0);
  endtask

  vec_t vecs[11];
  int   dc;

  initial begin
    vecs[0]  = '{"mult_neg3x7",      2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{"multu_max",        2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{"div_neg7_2",       2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{"divu_by_zero",     2'b11, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF};
    vecs[4]  = '{"div_overflow",     2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{"divu_100_7",       2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[6]  = '{"div_7_neg2",       2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[7]  = '{"mult_neg1sq",      2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[8]  = '{"div_neg7_by_zero", 2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[9]  = '{"mult_minsq",       2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[10] = '{"multu_shift",      2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};

    rst_n = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    tick(2);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hi",   64'(hi),   64'd0);
    chk("reset_lo",   64'(lo),   64'd0);
    rst_n = 1'b1;
    tick(1);

    // MTHI in idle, then MULTU 5x6 with a start + MTLO attempt mid-op
    hi_we = 1'b1; wdata = 32'h11111111;
    tick(1);
    hi_we = 1'b0;
    chk("mthi_hi", 64'(hi), 64'h11111111);
    chk("mthi_lo_untouched", 64'(lo), 64'd0);
    launch("multu_5x6", 2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 1'b1);
    tick(9);
    lo_we = 1'b1; hi_we = 1'b1; wdata = 32'hDEADBEEF;
    start = 1'b1; a = 32'd9; b = 32'd9; op = 2'b00;
    tick(1);
    lo_we = 1'b0; hi_we = 1'b0; start = 1'b0;
    chk("midop_lo", 64'(lo), 64'd0);
    chk("midop_hi", 64'(hi), 64'h11111111);
    chk("midop_busy", 64'(busy), 64'd1);
    finish_op();

    // Table of operations
    for (int i = 0; i < 11; i++) begin
      launch(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, 1'b1);
      finish_op();
    end

    // Both MT enables together, then start colliding with an MT write
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5A5A5;
    tick(1);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mt_both_hi", 64'(hi), 64'hA5A5A5A5);
    chk("mt_both_lo", 64'(lo), 64'hA5A5A5A5);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BADF00D;
    launch("start_beats_mt", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b1);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("start_beats_mt_hi_hold", 64'(hi), 64'hA5A5A5A5);
    finish_op();

    // Reset during CALC aborts with no done
    launch("abort", 2'b01, 32'd5, 32'd6, 32'd0, 32'd0, 1'b0);
    tick(19);
    dc = done_cnt;
    rst_n = 1'b0;
    tick(1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi",   64'(hi),   64'd0);
    chk("abort_lo",   64'(lo),   64'd0);
    rst_n = 1'b1;
    tick(40);
    chk("abort_no_done", 64'(done_cnt - dc), 64'd0);
    chk("abort_queue_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
